// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions for the register-file slave: response codes and
// the write-channel FSM state encoding.
package axil_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_WRITE   = 2'd1,
        S_RESP    = 2'd2
    } wr_state_e;

endpackage

// File: rtl/axil_hold_reg.sv
// One-entry valid/ready capture register. ready is registered so that it is low
// during reset and rises on the first edge after release.
module axil_hold_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             valid,
    output logic             ready,
    input  logic [WIDTH-1:0] data_in,
    output logic             full,
    output logic [WIDTH-1:0] data
);

    logic take;
    logic full_next;

    assign take      = valid && ready;
    assign full_next = clear ? 1'b0 : (full || take);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full  <= 1'b0;
            ready <= 1'b0;
        end else begin
            full  <= full_next;
            ready <= !full_next;
        end
    end

    // Payload is only meaningful while full, so it needs no reset.
    always_ff @(posedge clk) begin
        if (take) begin
            data <= data_in;
        end
    end

endmodule

// File: rtl/axil_slave_wr_ctrl.sv
// AXI4-Lite write-channel slave: independent AW/W holds, one-cycle back-end write
// pulse, single outstanding B. Define AXIL_WR_RANGE_CHK_EN to enable the address window check.
module axil_slave_wr_ctrl
    import axil_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                NUM_REGS  = 16,
    localparam int               STRB_W    = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              awvalid,
    output logic              awready,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              wvalid,
    output logic              wready,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    output logic              bvalid,
    input  logic              bready,
    output logic [1:0]        bresp,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [STRB_W-1:0] wr_strb
);

    localparam int ALIGN_W = $clog2(STRB_W);
    localparam int WHOLD_W = DATA_W + STRB_W;

    function automatic logic addr_in_window(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] hi;
        hi = BASE_ADDR + ADDR_W'(NUM_REGS * STRB_W);
        return (a >= BASE_ADDR) && (a < hi);
    endfunction

    wr_state_e          state;
    wr_state_e          state_next;
    logic               hold_clear;
    logic               aw_full;
    logic               w_full;
    logic [ADDR_W-1:0]  aw_hold_data;
    logic [WHOLD_W-1:0] w_hold_data;
    logic               aw_avail;
    logic               w_avail;
    logic [ADDR_W-1:0]  aw_cur;
    logic [WHOLD_W-1:0] w_cur;
    logic [DATA_W-1:0]  cur_data;
    logic [STRB_W-1:0]  cur_strb;
    logic               misaligned;
    logic               out_of_range;
    logic               wr_err;
    logic               go_write;

    assign hold_clear = (state == S_WRITE);

    axil_hold_reg #(.WIDTH(ADDR_W)) u_aw_hold (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (hold_clear),
        .valid   (awvalid),
        .ready   (awready),
        .data_in (awaddr),
        .full    (aw_full),
        .data    (aw_hold_data)
    );

    axil_hold_reg #(.WIDTH(WHOLD_W)) u_w_hold (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (hold_clear),
        .valid   (wvalid),
        .ready   (wready),
        .data_in ({wdata, wstrb}),
        .full    (w_full),
        .data    (w_hold_data)
    );

    // Look through a hold that is filling on this edge so wr_en follows the later handshake by one cycle.
    assign aw_avail = aw_full || (awvalid && awready);
    assign w_avail  = w_full || (wvalid && wready);
    assign aw_cur   = aw_full ? aw_hold_data : awaddr;
    assign w_cur    = w_full ? w_hold_data : {wdata, wstrb};
    assign cur_data = w_cur[WHOLD_W-1:STRB_W];
    assign cur_strb = w_cur[STRB_W-1:0];

    assign misaligned = |aw_cur[ALIGN_W-1:0];
`ifdef AXIL_WR_RANGE_CHK_EN
    assign out_of_range = !addr_in_window(aw_cur);
`else
    assign out_of_range = 1'b0;
`endif
    assign wr_err   = misaligned || out_of_range;
    assign go_write = (state == S_COLLECT) && aw_avail && w_avail;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_COLLECT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_COLLECT: if (go_write) state_next = S_WRITE;
            S_WRITE:   state_next = S_RESP;
            S_RESP:    if (bvalid && bready) state_next = S_COLLECT;
            default:   state_next = S_COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            wr_strb <= '0;
            bvalid  <= 1'b0;
            bresp   <= AXI_RESP_OKAY;
        end else begin
            wr_en <= go_write && !wr_err && (|cur_strb);
            if (go_write) begin
                wr_addr <= aw_cur;
                wr_data <= cur_data;
                wr_strb <= cur_strb;
                bresp   <= wr_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            end
            // bresp only changes on go_write, which cannot happen while bvalid is high.
            if (state == S_WRITE) begin
                bvalid <= 1'b1;
            end else if (bvalid && bready) begin
                bvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axil_slave_wr_ctrl.sv
// Bench for axil_slave_wr_ctrl: vector table, hand sequences for backpressure and
// reset, and a randomized stream checked against a transaction-level model.
module tb_axil_slave_wr_ctrl;
    import axil_pkg::*;

    localparam int          ADDR_W = 32;
    localparam int          DATA_W = 32;
    localparam int          STRB_W = 4;
    localparam logic [31:0] BASE   = 32'h100;
    localparam int          NREGS  = 4;
`ifdef AXIL_WR_RANGE_CHK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              awvalid = 1'b0;
    logic              awready;
    logic [ADDR_W-1:0] awaddr = '0;
    logic              wvalid = 1'b0;
    logic              wready;
    logic [DATA_W-1:0] wdata = '0;
    logic [STRB_W-1:0] wstrb = '0;
    logic              bvalid;
    logic              bready = 1'b0;
    logic [1:0]        bresp;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [STRB_W-1:0] wr_strb;

    axil_slave_wr_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE_ADDR(BASE), .NUM_REGS(NREGS)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic [31:0] data; logic [3:0] strb; int cyc; } wr_ev_t;
    typedef struct { logic [1:0] resp; int cyc; } b_ev_t;
    typedef struct {
        logic [31:0] addr; logic [31:0] data; logic [3:0] strb;
        int aw_gap; int w_gap; logic exp_wr; logic [1:0] exp_resp;
    } vec_t;

    int     cyc = 0;
    wr_ev_t act_wr[$];
    b_ev_t  act_b[$];
    int     aw_hs[$];
    int     w_hs[$];
    int     n_cmp = 0;
    int     n_bad = 0;

    logic       prev_bv = 1'b0;
    logic       prev_br = 1'b0;
    logic       prev_wr = 1'b0;
    logic [1:0] prev_resp = 2'b00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    // Outputs and handshakes are observed on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (awvalid && awready) aw_hs.push_back(cyc);
        if (wvalid && wready) w_hs.push_back(cyc);
        if (wr_en) act_wr.push_back('{wr_addr, wr_data, wr_strb, cyc});
        if (bvalid && bready) act_b.push_back('{bresp, cyc});
        if (rst_n && prev_bv && !prev_br) begin
            chk("b_hold_valid", bvalid, 1);
            chk("b_hold_resp", bresp, prev_resp);
        end
        if (prev_wr) chk("wr_en_single_pulse", wr_en, 0);
        prev_bv   <= bvalid;
        prev_br   <= bready;
        prev_wr   <= wr_en;
        prev_resp <= bresp;
    end

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Reference rule: misaligned or (with the range check) out-of-window addresses fail.
    function automatic logic [1:0] m_resp(input logic [31:0] a);
        logic bad;
        bad = (a % 4) != 0;
        if (RC && (a < BASE || a >= BASE + NREGS * 4)) bad = 1'b1;
        return bad ? 2'b10 : 2'b00;
    endfunction

    task automatic send_aw(input logic [31:0] a, input int gap);
        repeat (gap) begin @(posedge clk); #1; end
        awvalid = 1'b1;
        awaddr  = a;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (awready) break;
            if (i == 299) timeout("aw_handshake");
        end
        @(posedge clk); #1;
        awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int gap);
        repeat (gap) begin @(posedge clk); #1; end
        wvalid = 1'b1;
        wdata  = d;
        wstrb  = s;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (wready) break;
            if (i == 299) timeout("w_handshake");
        end
        @(posedge clk); #1;
        wvalid = 1'b0;
    endtask

    task automatic wait_b(input int target);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (act_b.size() >= target) return;
        end
        timeout("b_response");
    endtask

    vec_t       vt[7];
    int         nw0, nb0, hs;
    localparam int N = 40;
    logic [31:0] ra[N];
    logic [31:0] rd[N];
    logic [3:0]  rs[N];
    int          agap[N];
    int          wgap[N];
    wr_ev_t      exp_wr[$];
    logic [1:0]  exp_b[$];

    initial begin
        vt[0] = '{32'h8,   32'hDEADBEEF, 4'hF, 0, 0, !RC,  RC ? 2'b10 : 2'b00};
        vt[1] = '{32'h4,   32'h00001234, 4'h3, 4, 0, !RC,  RC ? 2'b10 : 2'b00};
        vt[2] = '{32'h6,   32'h11111111, 4'hF, 0, 0, 1'b0, 2'b10};
        vt[3] = '{32'h0,   32'h22222222, 4'h0, 0, 1, 1'b0, RC ? 2'b10 : 2'b00};
        vt[4] = '{32'h10C, 32'h33333333, 4'hF, 1, 2, 1'b1, 2'b00};
        vt[5] = '{32'h110, 32'h44444444, 4'hF, 2, 0, !RC,  RC ? 2'b10 : 2'b00};
        vt[6] = '{32'h100, 32'hCAFEF00D, 4'h5, 3, 1, 1'b1, 2'b00};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_awready", awready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_bresp", bresp, 0);
        chk("rst_wr_addr", wr_addr, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_awready_first", awready, 0);
        @(negedge clk);
        chk("rel_awready", awready, 1);
        chk("rel_wready", wready, 1);
        @(posedge clk); #1;

        // Vector table
        bready = 1'b1;
        for (int v = 0; v < 7; v++) begin
            nw0 = act_wr.size();
            nb0 = act_b.size();
            fork
                send_aw(vt[v].addr, vt[v].aw_gap);
                send_w(vt[v].data, vt[v].strb, vt[v].w_gap);
            join
            wait_b(nb0 + 1);
            repeat (3) @(negedge clk);
            hs = imax(aw_hs[$], w_hs[$]);
            chk($sformatf("v%0d_wr_count", v), act_wr.size() - nw0, vt[v].exp_wr);
            chk($sformatf("v%0d_b_count", v), act_b.size() - nb0, 1);
            if (act_wr.size() > nw0) begin
                chk($sformatf("v%0d_wr_addr", v), act_wr[nw0].addr, vt[v].addr);
                chk($sformatf("v%0d_wr_data", v), act_wr[nw0].data, vt[v].data);
                chk($sformatf("v%0d_wr_strb", v), act_wr[nw0].strb, vt[v].strb);
                chk($sformatf("v%0d_wr_latency", v), act_wr[nw0].cyc, hs + 1);
            end
            if (act_b.size() > nb0) begin
                chk($sformatf("v%0d_bresp", v), act_b[nb0].resp, vt[v].exp_resp);
                chk($sformatf("v%0d_b_latency", v), act_b[nb0].cyc, hs + 2);
            end
            @(posedge clk); #1;
        end

        // W well ahead of AW: the W hold fills and wready stays low until the pair completes
        nw0 = act_wr.size();
        nb0 = act_b.size();
        send_w(32'h00001234, 4'h3, 0);
        repeat (2) @(negedge clk);
        chk("wfirst_wready_low", wready, 0);
        chk("wfirst_awready_high", awready, 1);
        chk("wfirst_no_wr", act_wr.size(), nw0);
        @(posedge clk); #1;
        send_aw(32'h104, 1);
        wait_b(nb0 + 1);
        repeat (3) @(negedge clk);
        chk("wfirst_wr_count", act_wr.size() - nw0, 1);
        chk("wfirst_b_count", act_b.size() - nb0, 1);
        if (act_wr.size() > nw0) chk("wfirst_wr_strb", act_wr[nw0].strb, 4'h3);
        @(posedge clk); #1;

        // Backpressure on B: second pair is captured, then AW/W stall
        bready = 1'b0;
        nw0 = act_wr.size();
        nb0 = act_b.size();
        fork
            send_aw(32'h100, 0);
            send_w(32'hA5A50001, 4'hF, 0);
        join
        fork
            send_aw(32'h104, 0);
            send_w(32'h5A5A0002, 4'hF, 0);
        join
        repeat (10) begin
            @(negedge clk);
            chk("bp_bvalid", bvalid, 1);
            chk("bp_bresp", bresp, 2'b00);
            chk("bp_awready", awready, 0);
            chk("bp_wready", wready, 0);
        end
        chk("bp_one_wr", act_wr.size() - nw0, 1);
        @(posedge clk); #1;
        bready = 1'b1;
        wait_b(nb0 + 2);
        repeat (3) @(negedge clk);
        chk("bp_wr_total", act_wr.size() - nw0, 2);
        if (act_wr.size() >= nw0 + 2 && act_b.size() > nb0) begin
            chk("bp_second_wr_after_b", act_wr[nw0 + 1].cyc, act_b[nb0].cyc + 2);
            chk("bp_second_addr", act_wr[nw0 + 1].addr, 32'h104);
        end
        @(posedge clk); #1;

        // Reset with AW held and W not yet sent
        send_aw(32'h108, 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_awready", awready, 0);
        chk("mid_rst_bvalid", bvalid, 0);
        @(negedge clk);
        chk("post_rst_awready", awready, 1);
        chk("post_rst_wready", wready, 1);
        @(posedge clk); #1;
        nw0 = act_wr.size();
        nb0 = act_b.size();
        send_w(32'h00000077, 4'hF, 0);
        repeat (5) @(negedge clk);
        chk("post_rst_no_wr", act_wr.size(), nw0);
        chk("post_rst_no_b", act_b.size(), nb0);
        chk("post_rst_bvalid", bvalid, 0);
        @(posedge clk); #1;
        send_aw(32'h10C, 0);
        wait_b(nb0 + 1);
        repeat (3) @(negedge clk);
        chk("post_rst_pair_wr", act_wr.size() - nw0, 1);
        if (act_wr.size() > nw0) begin
            chk("post_rst_pair_addr", act_wr[nw0].addr, 32'h10C);
            chk("post_rst_pair_data", act_wr[nw0].data, 32'h77);
        end
        @(posedge clk); #1;

        // Randomized stream against the transaction model
        for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 7) == 0) ra[i] = BASE + $urandom_range(0, 31);
            else ra[i] = BASE - 16 + 4 * $urandom_range(0, 11);
            rd[i]   = $urandom;
            rs[i]   = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            agap[i] = $urandom_range(0, 3);
            wgap[i] = $urandom_range(0, 3);
            exp_b.push_back(m_resp(ra[i]));
            if (m_resp(ra[i]) == 2'b00 && rs[i] != 4'h0) exp_wr.push_back('{ra[i], rd[i], rs[i], 0});
        end
        nw0 = act_wr.size();
        nb0 = act_b.size();
        fork
            begin for (int i = 0; i < N; i++) send_aw(ra[i], agap[i]); end
            begin for (int j = 0; j < N; j++) send_w(rd[j], rs[j], wgap[j]); end
            begin
                for (int k = 0; k < 3000; k++) begin
                    @(posedge clk); #1;
                    bready = ($urandom_range(0, 9) < 7);
                    if (act_b.size() >= nb0 + N) break;
                end
                bready = 1'b1;
            end
        join
        wait_b(nb0 + N);
        repeat (3) @(negedge clk);
        chk("rnd_wr_count", act_wr.size() - nw0, exp_wr.size());
        chk("rnd_b_count", act_b.size() - nb0, N);
        for (int i = 0; i < exp_wr.size() && nw0 + i < act_wr.size(); i++) begin
            chk($sformatf("rnd_wr%0d_addr", i), act_wr[nw0 + i].addr, exp_wr[i].addr);
            chk($sformatf("rnd_wr%0d_data", i), act_wr[nw0 + i].data, exp_wr[i].data);
            chk($sformatf("rnd_wr%0d_strb", i), act_wr[nw0 + i].strb, exp_wr[i].strb);
        end
        for (int i = 0; i < N && nb0 + i < act_b.size(); i++) begin
            chk($sformatf("rnd_b%0d_resp", i), act_b[nb0 + i].resp, exp_b[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
